// File: rtl/video_mode_detect_if.sv
// Video timing in, detected raster mode out.
// master drives the video timing; slave is the detector.
interface video_mode_detect_if #(
    parameter int CNT_W = 12
);
    logic             vid_de;
    logic             vid_vsync;
    logic [1:0]       pu_type;
    logic             pu_valid;
    logic [CNT_W-1:0] meas_width;
    logic [CNT_W-1:0] meas_height;
    logic             frame_pulse;
    logic             mode_change;

    modport master (
        output vid_de,
        output vid_vsync,
        input  pu_type,
        input  pu_valid,
        input  meas_width,
        input  meas_height,
        input  frame_pulse,
        input  mode_change
    );

    modport slave (
        input  vid_de,
        input  vid_vsync,
        output pu_type,
        output pu_valid,
        output meas_width,
        output meas_height,
        output frame_pulse,
        output mode_change
    );
endinterface

// File: rtl/video_mode_detect.sv
// Measures DE raster per frame and reports a debounced resolution code.
// MODE*_W/H default to the real rasters; they only exist so short rasters can stand in.
module video_mode_detect #(
    parameter int VSYNC_POL      = 1,
    parameter int STABLE_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 4194304,
    parameter int CNT_W          = 12,
    parameter int MODE2_W        = 1920,
    parameter int MODE2_H        = 1080,
    parameter int MODE1_W        = 1024,
    parameter int MODE1_H        = 768,
    parameter int MODE0_W        = 640,
    parameter int MODE0_H        = 480
) (
    input logic              clock,
    input logic              reset,
    video_mode_detect_if.slave vif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [3:0] SFV = 4'(STABLE_FRAMES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic POL = VSYNC_POL[0];

    typedef enum logic {SEARCH, MEASURE} state_t;
    typedef enum logic [1:0] {
        C_640  = 2'd0,
        C_1024 = 2'd1,
        C_1080 = 2'd2,
        C_INV  = 2'd3
    } cls_t;

    logic de_r, de_d, vs_r, vs_d;
    logic fs, de_rise, de_fall, tmo;
    logic [CNT_W-1:0] pix, acc_w, acc_h;
    logic acc_mm;
    logic [CNT_W-1:0] eff_w, eff_h;
    logic eff_mm;
    logic [TW-1:0] tcnt;
    cls_t cls;

    state_t state, state_n;
    cls_t last, last_n;
    logic [3:0] stab, stab_n;
    logic [1:0] type_q, type_n;
    logic valid_q, valid_n;
    logic [CNT_W-1:0] mw_q, mw_n, mh_q, mh_n;
    logic fp_q, fp_n, mc_q, mc_n;

    assign fs      = vs_r & ~vs_d;
    assign de_rise = de_r & ~de_d;
    assign de_fall = ~de_r & de_d;
    assign tmo     = (tcnt == TLAST) && !fs;

    // A line ending in the fs cycle still belongs to the closing frame.
    always_comb begin
        eff_w  = acc_w;
        eff_h  = acc_h;
        eff_mm = acc_mm;
        if (de_fall) begin
            eff_h = (acc_h == CMAX) ? acc_h : acc_h + 1'b1;
            if (acc_h == '0)
                eff_w = pix;
            else if (pix != acc_w)
                eff_mm = 1'b1;
        end
    end

    always_comb begin
        cls = C_INV;
        if (!eff_mm && eff_h != '0) begin
            if (eff_w == CNT_W'(MODE2_W) && eff_h == CNT_W'(MODE2_H))
                cls = C_1080;
            else if (eff_w == CNT_W'(MODE1_W) && eff_h == CNT_W'(MODE1_H))
                cls = C_1024;
            else if (eff_w == CNT_W'(MODE0_W) && eff_h == CNT_W'(MODE0_H))
                cls = C_640;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            de_r   <= 1'b0;
            de_d   <= 1'b0;
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            pix    <= '0;
            acc_w  <= '0;
            acc_h  <= '0;
            acc_mm <= 1'b0;
            tcnt   <= '0;
        end else begin
            de_r <= vif.vid_de;
            de_d <= de_r;
            vs_r <= vif.vid_vsync ^ ~POL;
            vs_d <= vs_r;
            if (de_rise)
                pix <= CNT_W'(1);
            else if (de_r && pix != CMAX)
                pix <= pix + 1'b1;
            if (fs) begin
                acc_w  <= '0;
                acc_h  <= '0;
                acc_mm <= 1'b0;
            end else if (de_fall) begin
                acc_w  <= eff_w;
                acc_h  <= eff_h;
                acc_mm <= eff_mm;
            end
            if (fs || tmo)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        stab_n  = stab;
        type_n  = type_q;
        valid_n = valid_q;
        mw_n    = mw_q;
        mh_n    = mh_q;
        fp_n    = 1'b0;
        unique case (1'b1)
            fs: begin
                fp_n = 1'b1;
                if (state == SEARCH) begin
                    state_n = MEASURE;
                end else begin
                    mw_n = eff_w;
                    mh_n = eff_h;
                    if (cls == last) begin
                        if (stab != SFV)
                            stab_n = stab + 1'b1;
                    end else begin
                        stab_n = 4'd1;
                        last_n = cls;
                    end
                    if (stab_n == SFV) begin
                        valid_n = (cls != C_INV);
                        type_n  = (cls == C_INV) ? 2'd0 : cls;
                    end
                end
            end
            tmo: begin
                state_n = SEARCH;
                last_n  = C_INV;
                stab_n  = '0;
                type_n  = '0;
                valid_n = 1'b0;
                mw_n    = '0;
                mh_n    = '0;
            end
            default: ;
        endcase
        mc_n = (type_n != type_q) || (valid_n != valid_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SEARCH;
            last    <= C_INV;
            stab    <= '0;
            type_q  <= '0;
            valid_q <= 1'b0;
            mw_q    <= '0;
            mh_q    <= '0;
            fp_q    <= 1'b0;
            mc_q    <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            stab    <= stab_n;
            type_q  <= type_n;
            valid_q <= valid_n;
            mw_q    <= mw_n;
            mh_q    <= mh_n;
            fp_q    <= fp_n;
            mc_q    <= mc_n;
        end
    end

    assign vif.pu_type     = type_q;
    assign vif.pu_valid    = valid_q;
    assign vif.meas_width  = mw_q;
    assign vif.meas_height = mh_q;
    assign vif.frame_pulse = fp_q;
    assign vif.mode_change = mc_q;
endmodule

// File: tb/tb_video_mode_detect.sv
// Random and directed rasters against a frame-level reference model.
// Two DUTs share the stream: active-high vsync and inverted active-low vsync.
module tb_video_mode_detect;
    localparam int SF  = 3;
    localparam int TMO = 1000;
    localparam int CW  = 12;

    int mw_tab[3] = '{16, 20, 24};
    int mh_tab[3] = '{6, 8, 10};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic de = 1'b0;
    logic vs = 1'b0;

    always #5 clock = ~clock;

    video_mode_detect_if #(.CNT_W(CW)) vp ();
    video_mode_detect_if #(.CNT_W(CW)) vn ();

    assign vp.vid_de    = de;
    assign vp.vid_vsync = vs;
    assign vn.vid_de    = de;
    assign vn.vid_vsync = ~vs;

    video_mode_detect #(
        .VSYNC_POL(1), .STABLE_FRAMES(SF), .TIMEOUT_CYCLES(TMO), .CNT_W(CW),
        .MODE2_W(24), .MODE2_H(10), .MODE1_W(20), .MODE1_H(8),
        .MODE0_W(16), .MODE0_H(6)
    ) dut_p (.clock(clock), .reset(reset), .vif(vp));

    video_mode_detect #(
        .VSYNC_POL(0), .STABLE_FRAMES(SF), .TIMEOUT_CYCLES(TMO), .CNT_W(CW),
        .MODE2_W(24), .MODE2_H(10), .MODE1_W(20), .MODE1_H(8),
        .MODE0_W(16), .MODE0_H(6)
    ) dut_n (.clock(clock), .reset(reset), .vif(vn));

    int n_chk = 0;
    int n_pass = 0;
    int step = 0;
    int fs_step = 0;

    // reference model: one entry per completed line of the open frame
    int lw[$];
    int searching = 1;
    int stab = 0;
    int last = 3;
    int e_t = 0, e_v = 0, e_mw = 0, e_mh = 0, e_mc = 0;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        step++;
    endtask

    function automatic int classify();
        if (lw.size() == 0) return 3;
        foreach (lw[i]) if (lw[i] != lw[0]) return 3;
        for (int m = 0; m < 3; m++)
            if (lw[0] == mw_tab[m] && lw.size() == mh_tab[m]) return m;
        return 3;
    endfunction

    task automatic model_fs();
        int c, pt, pv;
        pt = e_t;
        pv = e_v;
        if (searching != 0) begin
            searching = 0;
        end else begin
            e_mw = (lw.size() > 0) ? lw[0] : 0;
            e_mh = lw.size();
            c = classify();
            if (c == last) begin
                if (stab < SF) stab++;
            end else begin
                stab = 1;
                last = c;
            end
            if (stab == SF) begin
                e_v = (c == 3) ? 0 : 1;
                e_t = (c == 3) ? 0 : c;
            end
        end
        e_mc = (pt != e_t || pv != e_v) ? 1 : 0;
        lw.delete();
    endtask

    task automatic model_clear();
        searching = 1;
        stab = 0;
        last = 3;
        e_t = 0; e_v = 0; e_mw = 0; e_mh = 0; e_mc = 0;
        lw.delete();
    endtask

    task automatic chk_all(string tag, int mc, int fp);
        chk({tag, " p.type"}, int'(vp.pu_type), e_t);
        chk({tag, " p.valid"}, int'(vp.pu_valid), e_v);
        chk({tag, " p.width"}, int'(vp.meas_width), e_mw);
        chk({tag, " p.height"}, int'(vp.meas_height), e_mh);
        chk({tag, " p.fpulse"}, int'(vp.frame_pulse), fp);
        chk({tag, " p.mchange"}, int'(vp.mode_change), mc);
        chk({tag, " n.type"}, int'(vn.pu_type), e_t);
        chk({tag, " n.valid"}, int'(vn.pu_valid), e_v);
        chk({tag, " n.width"}, int'(vn.meas_width), e_mw);
        chk({tag, " n.height"}, int'(vn.meas_height), e_mh);
        chk({tag, " n.fpulse"}, int'(vn.frame_pulse), fp);
        chk({tag, " n.mchange"}, int'(vn.mode_change), mc);
    endtask

    // vsync high 3 cycles; outputs of this fs are visible 2 cycles after it rises
    task automatic vsync_seg();
        tick(); vs = 1'b1; de = 1'b0;
        tick();
        tick(); model_fs(); fs_step = step; chk_all("fs", e_mc, 1);
        tick(); vs = 1'b0; chk_all("post_fs", 0, 0);
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        model_clear();
        chk_all("mid_reset", 0, 0);
    endtask

    task automatic frame(int w, int h, int bad_idx, int tail, int rst_line);
        int lwid;
        vsync_seg();
        repeat (2) tick();
        for (int i = 0; i < h; i++) begin
            lwid = (i == bad_idx) ? w - 1 : w;
            for (int p = 0; p < lwid; p++) begin
                tick(); de = 1'b1;
            end
            lw.push_back(lwid);
            if (!(tail != 0 && i == h - 1)) begin
                repeat (3) begin tick(); de = 1'b0; end
            end
            if (i == rst_line) do_reset();
        end
    endtask

    task automatic timeout_test();
        int mcp, mcn, atp, atn, exp_cnt;
        mcp = 0; mcn = 0; atp = -1; atn = -1;
        exp_cnt = (e_v != 0 || e_t != 0) ? 1 : 0;
        for (int i = 0; i < TMO + 100; i++) begin
            tick();
            if (vp.mode_change) begin mcp++; atp = step; end
            if (vn.mode_change) begin mcn++; atn = step; end
        end
        chk("tmo p.mc_count", mcp, exp_cnt);
        chk("tmo n.mc_count", mcn, exp_cnt);
        if (exp_cnt == 1) begin
            chk("tmo p.latency", atp - fs_step, TMO);
            chk("tmo n.latency", atn - fs_step, TMO);
        end
        model_clear();
        chk_all("tmo", 0, 0);
    endtask

    initial begin
        int m, run, w, h, bad;
        repeat (2) tick();
        chk_all("reset", 0, 0);
        reset = 1'b0;
        repeat (5) tick();

        repeat (4) frame(16, 6, -1, 0, -1);
        vsync_seg();
        chk("m0 valid", int'(vp.pu_valid), 1);
        chk("m0 width", int'(vp.meas_width), 16);

        repeat (4) frame(24, 10, -1, 0, -1);
        repeat (4) frame(20, 8, -1, 0, -1);
        frame(20, 8, 3, 0, -1);
        repeat (3) frame(20, 8, -1, 0, -1);
        vsync_seg();
        chk("m1 type", int'(vp.pu_type), 1);

        timeout_test();
        repeat (4) frame(16, 6, -1, 1, -1);
        frame(16, 6, -1, 1, -1);
        frame(16, 6, -1, 0, 2);
        repeat (4) frame(24, 10, -1, 0, -1);

        repeat (14) begin
            m = $urandom_range(0, 3);
            run = $urandom_range(1, 5);
            if (m < 3) begin
                w = mw_tab[m];
                h = mh_tab[m];
            end else begin
                w = $urandom_range(14, 26);
                h = $urandom_range(0, 11);
            end
            repeat (run) begin
                bad = -1;
                if (h > 0 && $urandom_range(0, 5) == 0)
                    bad = $urandom_range(0, h - 1);
                frame(w, h, bad, $urandom_range(0, 1), -1);
            end
        end
        vsync_seg();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/video_mode_detect.md
Name: video_mode_detect

Overview:
- Measures the active raster of the incoming video stream: DE-high pixels per line and DE lines per frame.
- Classifies the raster into the PU resolution code that the video core configurator reads on gp_inputs[5:4].
- Only reports a code after it has been stable for several consecutive frames, so that glitches do not retrigger mixer reconfiguration.
- Sits upstream of the configurator, in the same clock domain as the sampled video timing.

Parameters:
- VSYNC_POL, 1, active level of vid_vsync (1 = active-high, 0 = active-low).
- STABLE_FRAMES, 3, consecutive identical frame classifications required before pu_type/pu_valid change (range 1..15).
- TIMEOUT_CYCLES, 4194304, clock cycles without a frame start before the detector declares loss of signal.
- CNT_W, 12, width of the pixel and line counters and of the meas_* outputs.

Ports:
- clock  in  1  system/pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vid_de  in  1  data enable, synchronous to clock.
- vid_vsync  in  1  vertical sync, polarity given by VSYNC_POL.
- pu_type  out  2  resolution code: 2 = 1920x1080, 1 = 1024x768, 0 = 640x480 or unknown.
- pu_valid  out  1  pu_type reflects a stable, recognised mode.
- meas_width  out  CNT_W  pixels per line of the last completed frame.
- meas_height  out  CNT_W  lines in the last completed frame.
- frame_pulse  out  1  one-cycle pulse at each frame start.
- mode_change  out  1  one-cycle pulse whenever pu_type or pu_valid changes.

Behaviour:
- Reset values (clock and reset only; reset is synchronous and active-high):
  - All outputs 0.
  - Internal counters 0.
  - State SEARCH.
  - Stable counter 0; last class = INVALID.
- Input registering and edge detection:
  - vid_de and vid_vsync are registered once.
  - vsync is normalised to active-high: vs = vid_vsync ^ ~VSYNC_POL.
  - Frame start (fs) = rising edge of registered vs.
  - de_rise and de_fall are edges of registered de.
- Pixel counter:
  - Cleared to 1 on de_rise, then +1 per DE-high cycle.
  - Saturates at 2^CNT_W-1.
  - On de_fall the count is the line width. The first line of a frame latches the frame width; any later line with a different width sets the frame's mismatch flag.
- Line counter:
  - +1 on each de_fall; saturates at 2^CNT_W-1.
  - If de_fall and fs occur in the same cycle, that line belongs to the closing frame.
  - A line whose DE is still high across fs is counted in the new frame.
- States:
  - SEARCH: wait for the first fs. On fs, clear frame accumulators and go to MEASURE. No classification on this fs (the preceding frame is partial).
  - MEASURE, on each fs:
    - Latch meas_width and meas_height from the accumulators.
    - Classify the frame:
      - 2 if width==1920 and height==1080.
      - 1 if width==1024 and height==768.
      - 0 if width==640 and height==480.
      - INVALID if the mismatch flag is set, no lines were seen, or any other size.
    - Clear the accumulators.
    - frame_pulse = 1 for one cycle.
    - Classification, latching and outputs all take effect on the cycle after the registered fs edge.
- Stability rule (evaluated at each fs in MEASURE):
  - If class == last class, the stable counter increments, saturating at STABLE_FRAMES. Otherwise it is set to 1 and last class = class.
  - When the stable counter equals STABLE_FRAMES:
    - Valid class: pu_valid = 1, pu_type = class.
    - INVALID class: pu_valid = 0, pu_type = 0.
  - mode_change pulses for one cycle in the cycle pu_type or pu_valid actually changes; no pulse if both values are unchanged.
- Timeout:
  - A cycle counter is cleared on fs and otherwise increments.
  - On reaching TIMEOUT_CYCLES-1 (in any state):
    - pu_valid = 0, pu_type = 0, meas_* = 0.
    - Stable counter = 0, last class = INVALID.
    - State = SEARCH.
    - mode_change pulses if pu_valid or pu_type was nonzero.
  - If timeout and fs occur in the same cycle, fs wins.
- Reset asserted mid-frame: everything returns to reset values on the next clock; the first subsequent fs is treated as a SEARCH fs.
- Outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 4 frames of 640x480 (DE-high 640 cycles, 480 lines, vsync pulse) with STABLE_FRAMES=3 -> no classification at first fs. pu_valid=1, pu_type=0 and mode_change pulse after the 4th fs. meas_width=640, meas_height=480.
- Stable 1920x1080 (pu_type=2), then switch to 1024x768 -> pu_type holds 2 for 2 frames and becomes 1 at the 3rd complete 1024x768 fs, with one mode_change pulse.
- 1024x768 stream with one line of 1023 pixels in one frame -> that frame is INVALID and the stable counter resets. pu_type stays 1. Two more good frames alone do not re-validate; the third does (counter reaches 3).
- Stop vsync for TIMEOUT_CYCLES (override to 1000) while pu_valid=1 -> pu_valid=0, pu_type=0, meas_*=0, mode_change pulse. Resumed video requires 1 SEARCH fs plus 3 good frames.
- VSYNC_POL=0 with active-low vsync, and a de_fall coinciding with fs on the last line -> height counted as 480, not 479; frame_pulse is one cycle per frame.
- Assert reset for 1 cycle in the middle of frame 2 -> all outputs 0 next cycle; detection restarts from SEARCH.
